if_id_stage: RTL and testbench

IF/ID pipeline register with integrated load-use hazard detection. It captures each fetched instruction and its PC, decodes the register-index fields, and holds them for the decode stage. It detects a load in EX whose destination is read by the instruction in ID, and in that case it stalls the PC and itself for one cycle and requests a bubble into ID/EX. It sits between instruction fetch and the ID/EX register, and also takes the taken-branch flush from EX.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/hazard_detect.sv | 28 ++
 rtl/if_id_stage.sv | 84 ++++++++
 tb/tb_if_id_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: canonical NOP, the opcodes that matter for
// register-source usage, and the default register-index width.
package pipe_pkg;

    localparam int RF_ADDRESS_DEF = 5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags a load in EX whose destination is a
// source actually read by the live instruction in ID. Purely combinational.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RF_ADDRESS = RF_ADDRESS_DEF
) (
    input  logic [6:0]            opcode,
    input  logic [RF_ADDRESS-1:0] rs1,
    input  logic [RF_ADDRESS-1:0] rs2,
    input  logic                  valid,
    input  logic [2:0]            idex_memread,
    input  logic [RF_ADDRESS-1:0] idex_rdest,
    output logic                  hazard
);

    logic uses_rs1;
    logic uses_rs2;

    always_comb begin
        uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        uses_rs2 = (opcode == OP_RTYPE || opcode == OP_STORE || opcode == OP_BRANCH);
        // x0 is hardwired zero, so a load targeting it never creates a dependency
        hazard   = valid && (idex_memread != 3'd0) && (idex_rdest != '0) &&
                   ((uses_rs1 && rs1 == idex_rdest) || (uses_rs2 && rs2 == idex_rdest));
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with field decode, one-cycle load-use stall,
// branch flush and a saturating stall-cycle counter.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter int PC_W        = 9,
    parameter int INS_W       = 32,
    parameter int RF_ADDRESS  = RF_ADDRESS_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PC_W-1:0]        PC_in,
    input  logic [INS_W-1:0]       Instr_in,
    input  logic                   Flush,
    input  logic [2:0]             IDEX_MemRead,
    input  logic [RF_ADDRESS-1:0]  IDEX_RDest,
    output logic [PC_W-1:0]        PC_Out,
    output logic [PC_W-1:0]        PCPlus4_Out,
    output logic [INS_W-1:0]       Instr_Out,
    output logic                   Valid_Out,
    output logic [6:0]             opcode_Out,
    output logic [RF_ADDRESS-1:0]  RDest_Out,
    output logic [2:0]             Funct3_Out,
    output logic [RF_ADDRESS-1:0]  RS1_Out,
    output logic [RF_ADDRESS-1:0]  RS2_Out,
    output logic [6:0]             Funct7_Out,
    output logic                   PCWrite,
    output logic                   Bubble,
    output logic [STALL_CNT_W-1:0] StallCount
);

    logic hazard;
    logic stall;

    assign opcode_Out = Instr_Out[6:0];
    assign RDest_Out  = Instr_Out[11:7];
    assign Funct3_Out = Instr_Out[14:12];
    assign RS1_Out    = Instr_Out[19:15];
    assign RS2_Out    = Instr_Out[24:20];
    assign Funct7_Out = Instr_Out[31:25];

    hazard_detect #(.RF_ADDRESS(RF_ADDRESS)) u_hazard (
        .opcode       (opcode_Out),
        .rs1          (RS1_Out),
        .rs2          (RS2_Out),
        .valid        (Valid_Out),
        .idex_memread (IDEX_MemRead),
        .idex_rdest   (IDEX_RDest),
        .hazard       (hazard)
    );

    // A flushed instruction is dead, so its dependency must not stall
    assign stall   = hazard && !Flush;
    assign PCWrite = !stall;
    assign Bubble  = stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC_Out      <= '0;
            PCPlus4_Out <= '0;
            Instr_Out   <= NOP_INSTR[INS_W-1:0];
            Valid_Out   <= 1'b0;
        end else if (Flush) begin
            PC_Out      <= PC_in;
            PCPlus4_Out <= PC_in + PC_W'(4);
            Instr_Out   <= NOP_INSTR[INS_W-1:0];
            Valid_Out   <= 1'b0;
        end else if (!stall) begin
            PC_Out      <= PC_in;
            PCPlus4_Out <= PC_in + PC_W'(4);
            Instr_Out   <= Instr_in;
            Valid_Out   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            StallCount <= '0;
        else if (stall && StallCount != '1)
            StallCount <= StallCount + 1'b1;
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, load-use stall, false-stall
// cases, flush priority, PC wrap, reset during stall, counter saturation.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  PC_in;
    logic [31:0] Instr_in;
    logic        Flush;
    logic [2:0]  IDEX_MemRead;
    logic [4:0]  IDEX_RDest;
    logic [8:0]  PC_Out, PCPlus4_Out;
    logic [31:0] Instr_Out;
    logic        Valid_Out;
    logic [6:0]  opcode_Out, Funct7_Out;
    logic [4:0]  RDest_Out, RS1_Out, RS2_Out;
    logic [2:0]  Funct3_Out;
    logic        PCWrite, Bubble;
    logic [15:0] StallCount;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ADD_X3 = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] ADDI_A = 32'h00A00093; // addi x1,x0,10
    localparam logic [31:0] ADDI_B = 32'h00100113; // addi x2,x0,1
    localparam logic [31:0] LUI_X5 = 32'h000012B7; // lui x5,1
    localparam logic [31:0] ADDI_C = 32'h00130213; // addi x4,x6,1
    localparam logic [31:0] SW_X5  = 32'h0053A023; // sw x5,0(x7)

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .Instr_in(Instr_in),
        .Flush(Flush), .IDEX_MemRead(IDEX_MemRead), .IDEX_RDest(IDEX_RDest),
        .PC_Out(PC_Out), .PCPlus4_Out(PCPlus4_Out), .Instr_Out(Instr_Out),
        .Valid_Out(Valid_Out), .opcode_Out(opcode_Out), .RDest_Out(RDest_Out),
        .Funct3_Out(Funct3_Out), .RS1_Out(RS1_Out), .RS2_Out(RS2_Out),
        .Funct7_Out(Funct7_Out), .PCWrite(PCWrite), .Bubble(Bubble),
        .StallCount(StallCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge, then settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; PC_in = 9'h010; Instr_in = ADDI_A; Flush = 1'b0;
        IDEX_MemRead = 3'd0; IDEX_RDest = 5'd0;

        repeat (2) tick();
        chk("rst_instr",  Instr_Out,  32'h00000013);
        chk("rst_valid",  Valid_Out,  0);
        chk("rst_scnt",   StallCount, 0);
        chk("rst_pcw",    PCWrite,    1);
        chk("rst_bubble", Bubble,     0);
        chk("rst_pc",     PC_Out,     0);
        chk("rst_pc4",    PCPlus4_Out,0);
        chk("rst_opc",    opcode_Out, 7'b0010011);

        rst_n = 1'b1;
        tick();
        chk("first_pc",    PC_Out,      9'h010);
        chk("first_pc4",   PCPlus4_Out, 9'h014);
        chk("first_instr", Instr_Out,   ADDI_A);
        chk("first_valid", Valid_Out,   1);
        chk("first_rd",    RDest_Out,   1);

        // load-use on rs1
        PC_in = 9'h020; Instr_in = ADD_X3;
        tick();
        PC_in = 9'h024; Instr_in = ADDI_B; IDEX_MemRead = 3'b010; IDEX_RDest = 5'd1;
        #1;
        chk("add_opc", opcode_Out, 7'b0110011);
        chk("add_rs1", RS1_Out, 1);
        chk("add_rs2", RS2_Out, 2);
        chk("add_rd",  RDest_Out, 3);
        chk("add_f3f7", {Funct7_Out, Funct3_Out}, 0);
        chk("lu_pcw",    PCWrite, 0);
        chk("lu_bubble", Bubble,  1);
        chk("lu_scnt0",  StallCount, 0);
        tick();
        chk("lu_hold_instr", Instr_Out, ADD_X3);
        chk("lu_hold_pc",    PC_Out,    9'h020);
        chk("lu_scnt1",      StallCount, 1);
        IDEX_MemRead = 3'd0;
        #1;
        chk("lu_clear_pcw", PCWrite, 1);
        tick();
        chk("adv_instr", Instr_Out, ADDI_B);
        chk("adv_pc",    PC_Out,    9'h024);

        // addi x2,x0,1 with load to x0: rs1 == rdest == 0 must not stall
        IDEX_MemRead = 3'b010; IDEX_RDest = 5'd0;
        #1;
        chk("x0_pcw", PCWrite, 1);

        // LUI with load to x0
        IDEX_MemRead = 3'd0; Instr_in = LUI_X5;
        tick();
        IDEX_MemRead = 3'b010; IDEX_RDest = 5'd0;
        #1;
        chk("lui_bubble", Bubble, 0);
        IDEX_RDest = 5'd0; IDEX_MemRead = 3'd0; Instr_in = ADDI_C;
        tick();
        IDEX_MemRead = 3'b001; IDEX_RDest = 5'd0;
        #1;
        chk("addi_x0_pcw", PCWrite, 1);
        IDEX_RDest = 5'd6;
        #1;
        chk("addi_rs1_pcw", PCWrite, 0);
        IDEX_RDest = 5'd1;  // matches unused rs2 field
        #1;
        chk("addi_rs2_pcw", PCWrite, 1);

        // store reads rs2
        IDEX_MemRead = 3'd0; Instr_in = SW_X5;
        tick();
        IDEX_MemRead = 3'b010; IDEX_RDest = 5'd5;
        #1;
        chk("sw_rs2_bubble", Bubble, 1);

        // flush wins over hazard
        IDEX_MemRead = 3'd0; Instr_in = ADD_X3;
        tick();
        IDEX_MemRead = 3'b010; IDEX_RDest = 5'd1; Flush = 1'b1;
        #1;
        chk("fl_pcw",    PCWrite, 1);
        chk("fl_bubble", Bubble,  0);
        tick();
        chk("fl_valid", Valid_Out, 0);
        chk("fl_instr", Instr_Out, 32'h00000013);
        chk("fl_scnt",  StallCount, 1);

        // PC wrap
        Flush = 1'b0; IDEX_MemRead = 3'd0; PC_in = 9'h1FC; Instr_in = ADD_X3;
        tick();
        chk("wrap_pc",  PC_Out,      9'h1FC);
        chk("wrap_pc4", PCPlus4_Out, 9'h000);

        // reset during stall
        IDEX_MemRead = 3'b010; IDEX_RDest = 5'd1; rst_n = 1'b0;
        tick();
        chk("rs_valid", Valid_Out, 0);
        chk("rs_instr", Instr_Out, 32'h00000013);
        chk("rs_scnt",  StallCount, 0);
        chk("rs_pcw",   PCWrite, 1);

        // saturation: hold hazard for 2^16 + 3 stall cycles
        rst_n = 1'b1; IDEX_MemRead = 3'd0; PC_in = 9'h030;
        tick();
        IDEX_MemRead = 3'b010;
        repeat (65539) @(posedge clk);
        #1;
        chk("sat_scnt", StallCount, 16'hFFFF);
        chk("sat_pc",   PC_Out,     9'h030);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
